// File: rtl/j204c_csr_init_pkg.sv
// +--------------------------------------------------------------------------+
// | j204c_csr_init_pkg                                                       |
// | Shared types for the JESD204C CSR init master.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package j204c_csr_init_pkg;

    localparam int c_wait_cnt_w = 24;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_POLL  = 2'd1,
        OP_WAIT  = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_POLL_TIMEOUT = 2'd1,
        ERR_VERIFY       = 2'd2
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD       = 3'd2,
        ST_POLL_RD  = 3'd3,
        ST_POLL_GAP = 3'd4,
        ST_WAIT     = 3'd5,
        ST_VFY_RD   = 3'd6,
        ST_ERR      = 3'd7
    } state_e;

    // A WAIT of zero still occupies one cycle.
    function automatic logic [c_wait_cnt_w-1:0] wait_len(input logic [c_wait_cnt_w-1:0] n);
        return (n == '0) ? c_wait_cnt_w'(1) : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/j204c_csr_init_timer.sv
// +--------------------------------------------------------------------------+
// | j204c_csr_init_timer                                                     |
// | Loadable down-counter; done is high on the last counted cycle.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module j204c_csr_init_timer
    import j204c_csr_init_pkg::*;
#(
    parameter int W = c_wait_cnt_w
)(
    input  logic         mgmt_clk,
    input  logic         mgmt_reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign done = (r_cnt <= W'(1));

endmodule

`default_nettype wire

// File: rtl/j204c_csr_init_master.sv
// +--------------------------------------------------------------------------+
// | j204c_csr_init_master                                                    |
// | Avalon-MM initiator executing WRITE/READ/POLL/WAIT CSR commands.         |
// | Optional write-verify readback: define J204C_CSR_INIT_READBACK_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module j204c_csr_init_master
    import j204c_csr_init_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int POLL_TIMEOUT = 4096,
    parameter int POLL_GAP     = 16
)(
    input  logic              mgmt_clk,
    input  logic              mgmt_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic [31:0]       cmd_mask,
    output logic              avs_chipselect,
    output logic [ADDR_W-1:0] avs_address,
    output logic              avs_read,
    output logic              avs_write,
    output logic [31:0]       avs_writedata,
    input  logic [31:0]       avs_readdata,
    input  logic              avs_waitrequest,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              clr_err
);

    localparam int c_att_w = $clog2(POLL_TIMEOUT + 1);

    state_e                  r_state;
    state_e                  w_next_state;
    logic [31:0]             r_data;
    logic [31:0]             r_mask;
    logic [c_att_w-1:0]      r_attempts;
    logic                    w_accept;
    logic                    w_match;
    logic                    w_poll_miss;
    logic                    w_enter_err;
    err_code_e               w_err_code;
    logic                    w_timer_load;
    logic [c_wait_cnt_w-1:0] w_timer_val;
    logic                    w_timer_done;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid && cmd_ready;
    assign w_match  = ((avs_readdata ^ r_data) & r_mask) == 32'd0;

    j204c_csr_init_timer #(
        .W (c_wait_cnt_w)
    ) u_timer (
        .mgmt_clk     (mgmt_clk),
        .mgmt_reset_n (mgmt_reset_n),
        .load         (w_timer_load),
        .load_val     (w_timer_val),
        .done         (w_timer_done)
    );

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timer_load = 1'b0;
        w_timer_val  = wait_len(cmd_data[c_wait_cnt_w-1:0]);
        w_poll_miss  = 1'b0;
        w_enter_err  = 1'b0;
        w_err_code   = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op_e'(cmd_op))
                        OP_WRITE: w_next_state = ST_WR;
                        OP_READ:  w_next_state = ST_RD;
                        OP_POLL:  w_next_state = ST_POLL_RD;
                        OP_WAIT: begin
                            w_next_state = ST_WAIT;
                            w_timer_load = 1'b1;
                        end
                        default:  w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_WR: begin
                if (!avs_waitrequest) begin
`ifdef J204C_CSR_INIT_READBACK_EN
                    w_next_state = ST_VFY_RD;
`else
                    w_next_state = ST_IDLE;
`endif
                end
            end
            ST_RD: begin
                if (!avs_waitrequest) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_POLL_RD: begin
                if (!avs_waitrequest) begin
                    if (w_match) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_poll_miss = 1'b1;
                        if (r_attempts + c_att_w'(1) == c_att_w'(POLL_TIMEOUT)) begin
                            w_next_state = ST_ERR;
                            w_enter_err  = 1'b1;
                            w_err_code   = ERR_POLL_TIMEOUT;
                        end else begin
                            w_next_state = ST_POLL_GAP;
                            w_timer_load = 1'b1;
                            w_timer_val  = c_wait_cnt_w'(POLL_GAP);
                        end
                    end
                end
            end
            ST_POLL_GAP: begin
                if (w_timer_done) begin
                    w_next_state = ST_POLL_RD;
                end
            end
            ST_WAIT: begin
                if (w_timer_done) begin
                    w_next_state = ST_IDLE;
                end
            end
`ifdef J204C_CSR_INIT_READBACK_EN
            ST_VFY_RD: begin
                if (!avs_waitrequest) begin
                    if (w_match) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_ERR;
                        w_enter_err  = 1'b1;
                        w_err_code   = ERR_VERIFY;
                    end
                end
            end
`endif
            ST_ERR: begin
                if (clr_err) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            r_data     <= '0;
            r_mask     <= '0;
            r_attempts <= '0;
        end else if (w_accept) begin
            r_data     <= cmd_data;
            r_mask     <= cmd_mask;
            r_attempts <= '0;
        end else if (w_poll_miss) begin
            r_attempts <= r_attempts + c_att_w'(1);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            avs_chipselect <= 1'b0;
            avs_read       <= 1'b0;
            avs_write      <= 1'b0;
            avs_address    <= '0;
            avs_writedata  <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            err            <= 1'b0;
            err_code       <= ERR_NONE;
        end else begin
            cmd_ready      <= (w_next_state == ST_IDLE);
            busy           <= (w_next_state != ST_IDLE);
            avs_write      <= (w_next_state == ST_WR);
            avs_read       <= (w_next_state == ST_RD) || (w_next_state == ST_POLL_RD) ||
                              (w_next_state == ST_VFY_RD);
            avs_chipselect <= (w_next_state == ST_WR) || (w_next_state == ST_RD) ||
                              (w_next_state == ST_POLL_RD) || (w_next_state == ST_VFY_RD);
            if (w_accept) begin
                avs_address <= cmd_addr;
                if (op_e'(cmd_op) == OP_WRITE) begin
                    avs_writedata <= cmd_data;
                end
            end
            rsp_valid <= (r_state == ST_RD) && !avs_waitrequest;
            if ((r_state == ST_RD) && !avs_waitrequest) begin
                rsp_data <= avs_readdata;
            end
            err <= (w_next_state == ST_ERR);
            if (w_enter_err) begin
                err_code <= w_err_code;
            end else if (w_next_state != ST_ERR) begin
                err_code <= ERR_NONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_j204c_csr_init_master.sv
// +--------------------------------------------------------------------------+
// | tb_j204c_csr_init_master                                                 |
// | Directed self-checking bench; readback tests use J204C_CSR_INIT_READBACK_EN.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_j204c_csr_init_master;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_GAP     = 3;
`ifdef J204C_CSR_INIT_READBACK_EN
    localparam int WR_CYC = 3;
`else
    localparam int WR_CYC = 2;
`endif

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset_n = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        avs_chipselect;
    logic [9:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic        clr_err;

    int n_vec = 0;
    int n_err = 0;

    j204c_csr_init_master #(
        .ADDR_W       (10),
        .POLL_TIMEOUT (TB_TIMEOUT),
        .POLL_GAP     (TB_GAP)
    ) dut (
        .mgmt_clk        (mgmt_clk),
        .mgmt_reset_n    (mgmt_reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .cmd_mask        (cmd_mask),
        .avs_chipselect  (avs_chipselect),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .busy            (busy),
        .err             (err),
        .err_code        (err_code),
        .clr_err         (clr_err)
    );

    always #5 mgmt_clk = ~mgmt_clk;

    task automatic tick;
        @(posedge mgmt_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [9:0] addr,
                         input logic [31:0] data, input logic [31:0] mask);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_mask  = mask;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0;
        clr_err = 0; avs_waitrequest = 0; avs_readdata = 0;
        mgmt_reset_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({cmd_ready, busy, avs_chipselect, avs_read, avs_write, rsp_valid, err} !== 7'b0 ||
            err_code !== 2'd0 || avs_address !== 10'd0 || avs_writedata !== 32'd0 || rsp_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b busy=%b cs=%b rd=%b wr=%b err=%b code=%0d, want all 0",
                     cmd_ready, busy, avs_chipselect, avs_read, avs_write, err, err_code);
        end
        mgmt_reset_n = 1'b1;
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_at_release: got %b, want 0", cmd_ready);
        end
        tick();
        n_vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_release: got ready=%b busy=%b, want ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_write;
        int n_wr = 0;
        int ready_at = 0;
        logic bad = 1'b0;
        avs_readdata = 32'h3;
        issue(2'd0, 10'h054, 32'h0000_0003, 32'h0000_000F);
        for (int i = 1; i <= 8; i++) begin
            if (avs_write) begin
                n_wr++;
                if (avs_address !== 10'h054 || avs_writedata !== 32'h3 || avs_chipselect !== 1'b1) bad = 1'b1;
            end
            if (cmd_ready && ready_at == 0) ready_at = i;
            tick();
        end
        n_vec++;
        if (n_wr != 1) begin
            n_err++;
            $display("FAIL write_count: got %0d cycles, want 1", n_wr);
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL write_fields: got bad address/data/chipselect, want 0x054/3/1");
        end
        n_vec++;
        if (ready_at != WR_CYC) begin
            n_err++;
            $display("FAIL write_ready_return: got %0d, want %0d", ready_at, WR_CYC);
        end
    endtask

    task automatic test_read;
        int n_rd = 0;
        int n_rsp = 0;
        int last_rd = 0;
        int rsp_at = 0;
        logic [31:0] got = 32'h0;
        logic bad_addr = 1'b0;
        issue(2'd3, 10'h060, 32'h0, 32'h0);
        for (int i = 1; i <= 15; i++) begin
            if (rsp_valid) begin
                n_rsp++;
                rsp_at = i;
                got = rsp_data;
            end
            if (avs_read) begin
                n_rd++;
                last_rd = i;
                if (avs_address !== 10'h060) bad_addr = 1'b1;
                avs_waitrequest = (n_rd < 6);
            end else begin
                avs_waitrequest = 1'b0;
            end
            avs_readdata = avs_waitrequest ? 32'hDEAD_BEEF : 32'hA5A5_0001;
            tick();
        end
        avs_waitrequest = 1'b0;
        n_vec++;
        if (n_rd != 6) begin
            n_err++;
            $display("FAIL read_hold: got %0d cycles, want 6", n_rd);
        end
        n_vec++;
        if (n_rsp != 1 || rsp_at != last_rd + 1) begin
            n_err++;
            $display("FAIL read_rsp_pulse: got %0d pulses at %0d, want 1 at %0d", n_rsp, rsp_at, last_rd + 1);
        end
        n_vec++;
        if (got !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL read_rsp_data: got %h, want a5a50001", got);
        end
        n_vec++;
        if (bad_addr) begin
            n_err++;
            $display("FAIL read_address: got wrong address, want 060");
        end
    endtask

    task automatic test_poll_match;
        int n_rd = 0;
        int rd_at [1:8];
        for (int k = 1; k <= 8; k++) rd_at[k] = 0;
        avs_readdata = 32'hFFFF_FFFE;
        issue(2'd1, 10'h080, 32'h1, 32'h1);
        for (int i = 1; i <= 40; i++) begin
            if (avs_read) begin
                n_rd++;
                if (n_rd <= 8) rd_at[n_rd] = i;
                avs_readdata = (n_rd >= 3) ? 32'h8000_0001 : 32'hFFFF_FFFE;
            end
            tick();
        end
        n_vec++;
        if (n_rd != 3) begin
            n_err++;
            $display("FAIL poll_read_count: got %0d, want 3", n_rd);
        end
        n_vec++;
        if (rd_at[2] - rd_at[1] - 1 != TB_GAP || rd_at[3] - rd_at[2] - 1 != TB_GAP) begin
            n_err++;
            $display("FAIL poll_gap: got %0d and %0d idle cycles, want %0d",
                     rd_at[2] - rd_at[1] - 1, rd_at[3] - rd_at[2] - 1, TB_GAP);
        end
        n_vec++;
        if (err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL poll_match_end: got err=%b ready=%b, want err=0 ready=1", err, cmd_ready);
        end
    endtask

    task automatic test_poll_timeout;
        int n_rd = 0;
        int last_rd = 0;
        int err_at = 0;
        logic leaked = 1'b0;
        avs_readdata = 32'h0;
        issue(2'd1, 10'h084, 32'h5, 32'hF);
        for (int i = 1; i <= 60; i++) begin
            if (avs_read) begin
                n_rd++;
                last_rd = i;
            end
            if (err && err_at == 0) err_at = i;
            tick();
        end
        n_vec++;
        if (n_rd != TB_TIMEOUT) begin
            n_err++;
            $display("FAIL timeout_read_count: got %0d, want %0d", n_rd, TB_TIMEOUT);
        end
        n_vec++;
        if (err !== 1'b1 || err_code !== 2'd1 || err_at != last_rd + 1) begin
            n_err++;
            $display("FAIL timeout_err: got err=%b code=%0d at %0d, want err=1 code=1 at %0d",
                     err, err_code, err_at, last_rd + 1);
        end
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 10'h1; cmd_data = 32'h1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (avs_write || cmd_ready) leaked = 1'b1;
        end
        cmd_valid = 1'b0;
        n_vec++;
        if (leaked) begin
            n_err++;
            $display("FAIL err_blocks_cmd: got command accepted in ERR, want blocked");
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_vec++;
        if (err !== 1'b0 || err_code !== 2'd0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clr_err: got err=%b code=%0d ready=%b, want 0/0/1", err, err_code, cmd_ready);
        end
    endtask

    task automatic test_wait(input logic [31:0] count, input int exp_busy);
        int n_busy = 0;
        int n_bus = 0;
        issue(2'd2, 10'h0, count, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            if (busy) n_busy++;
            if (avs_chipselect || avs_read || avs_write) n_bus++;
            tick();
        end
        n_vec++;
        if (n_busy != exp_busy) begin
            n_err++;
            $display("FAIL wait_busy_%0d: got %0d cycles, want %0d", count, n_busy, exp_busy);
        end
        n_vec++;
        if (n_bus != 0) begin
            n_err++;
            $display("FAIL wait_bus_%0d: got %0d active cycles, want 0", count, n_bus);
        end
    endtask

    task automatic test_back_to_back;
        int n_acc = 0;
        int n_wr = 0;
        int wr_at [0:1];
        logic [9:0]  wa [0:1];
        logic [31:0] wd [0:1];
        logic acc;
        for (int k = 0; k < 2; k++) begin
            wr_at[k] = 0; wa[k] = '0; wd[k] = '0;
        end
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 10'h010; cmd_data = 32'hAA; cmd_mask = 32'hFFFF_FFFF;
        for (int i = 1; i <= 12; i++) begin
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    cmd_addr = 10'h011;
                    cmd_data = 32'hBB;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (avs_write) begin
                if (n_wr < 2) begin
                    wr_at[n_wr] = i; wa[n_wr] = avs_address; wd[n_wr] = avs_writedata;
                end
                n_wr++;
            end
            if (avs_read) avs_readdata = avs_writedata;
        end
        cmd_valid = 1'b0;
        n_vec++;
        if (n_wr != 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d writes, want 2", n_wr);
        end
        n_vec++;
        if (wa[0] !== 10'h010 || wd[0] !== 32'hAA || wa[1] !== 10'h011 || wd[1] !== 32'hBB) begin
            n_err++;
            $display("FAIL b2b_fields: got %h/%h then %h/%h, want 010/aa then 011/bb", wa[0], wd[0], wa[1], wd[1]);
        end
        n_vec++;
        if (wr_at[1] - wr_at[0] != WR_CYC) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d, want %0d", wr_at[1] - wr_at[0], WR_CYC);
        end
    endtask

`ifdef J204C_CSR_INIT_READBACK_EN
    task automatic test_verify_mismatch;
        avs_readdata = 32'h0000_1230;
        issue(2'd0, 10'h100, 32'h0000_1234, 32'h0000_FFFF);
        repeat (6) tick();
        n_vec++;
        if (err !== 1'b1 || err_code !== 2'd2 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL verify_mismatch: got err=%b code=%0d ready=%b, want 1/2/0", err, err_code, cmd_ready);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_vec++;
        if (err !== 1'b0 || err_code !== 2'd0) begin
            n_err++;
            $display("FAIL verify_clr: got err=%b code=%0d, want 0/0", err, err_code);
        end
    endtask
`endif

    task automatic test_reset_mid_transfer;
        avs_waitrequest = 1'b1;
        issue(2'd0, 10'h003, 32'h77, 32'h0);
        tick();
        n_vec++;
        if (avs_write !== 1'b1 || avs_address !== 10'h003) begin
            n_err++;
            $display("FAIL stall_hold: got wr=%b addr=%h, want 1/003", avs_write, avs_address);
        end
        mgmt_reset_n = 1'b0;
        #1;
        n_vec++;
        if ({avs_write, avs_read, avs_chipselect, busy, cmd_ready, err} !== 6'b0 ||
            avs_address !== 10'd0 || avs_writedata !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: got wr=%b cs=%b busy=%b addr=%h, want all 0",
                     avs_write, avs_chipselect, busy, avs_address);
        end
        avs_waitrequest = 1'b0;
        mgmt_reset_n = 1'b1;
        tick();
        n_vec++;
        if (cmd_ready !== 1'b1 || avs_write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_recover: got ready=%b wr=%b, want 1/0", cmd_ready, avs_write);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_timeout();
        test_wait(32'd10, 10);
        test_wait(32'd0, 1);
        test_back_to_back();
`ifdef J204C_CSR_INIT_READBACK_EN
        test_verify_mismatch();
`endif
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
